// File: rtl/irrig_pkg.sv
// Shared types for the irrigation tank FSM and its phase scheduler.
package irrig_pkg;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ST_W  = 3;

    // Tank FSM state encodings as seen on the scheduler's state input.
    typedef enum logic [ST_W-1:0] {
        TK_ENCHENDO  = 3'b000,
        TK_CHEIO     = 3'b001,
        TK_GOTEJANDO = 3'b010,
        TK_ASPERSAO  = 3'b011,
        TK_LIMPEZA   = 3'b100,
        TK_ERRO      = 3'b101
    } tank_state_e;

    // Scheduler phases.
    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_GOTEJO   = 2'b01,
        S_ASPERSAO = 2'b10,
        S_LIMPEZA  = 2'b11
    } sched_state_e;

endpackage

// File: rtl/irrig_scheduler_tick_timer.sv
// Loadable down-counter advanced by the tick time base; stops at zero.
module tick_timer
    import irrig_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    input  logic             tick_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear beats load, load beats a coincident tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/irrig_scheduler.sv
// Irrigation phase scheduler: picks drip/sprinkler phases, times them,
// runs the cleaning interval and watches the tank fill time.
module irrig_scheduler
    import irrig_pkg::*;
#(
    parameter int unsigned T_GOTEJO    = 60,
    parameter int unsigned T_ASPERSAO  = 30,
    parameter int unsigned T_LIMPEZA   = 10,
    parameter int unsigned T_ENCHE_MAX = 120
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [ST_W-1:0]  state,
    input  logic             seco,
    input  logic             umido,
    input  logic             temp_alta,
    input  logic             modo_manual,
    input  logic             man_gotejo,
    input  logic             man_aspersao,
    output logic             gotejamento,
    output logic             aspersao,
    output logic             countLi,
    output logic [CNT_W-1:0] tempo_restante,
    output logic             alarme_enche
);

    sched_state_e     sched_q, sched_d;
    logic             got_q, got_d;
    logic             asp_q, asp_d;
    logic             countli_q, countli_d;
    logic             alarme_q, alarme_d;
    logic             manual_q, manual_d;
    logic             li_loaded_q, li_loaded_d;
    logic [CNT_W-1:0] fill_q, fill_d;

    logic             tmr_clear, tmr_load, tmr_en;
    logic [CNT_W-1:0] tmr_val, tmr_cnt;
    logic             sel_got_c, sel_asp_c, man_sel_c, stop_c;

    tick_timer u_phase_timer (
        .clk        (clk),
        .rst        (reset),
        .clear_i    (tmr_clear),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .tick_i     (tick),
        .cnt_o      (tmr_cnt)
    );

    // Phase selection from sensors (auto) or requests (manual, drip first).
    always_comb begin
        sel_got_c = 1'b0;
        sel_asp_c = 1'b0;
        if (modo_manual) begin
            sel_got_c = man_gotejo;
            sel_asp_c = !man_gotejo && man_aspersao;
        end else begin
            sel_got_c = seco && !temp_alta;
            sel_asp_c = seco && temp_alta;
        end
        man_sel_c = (sched_q == S_GOTEJO) ? man_gotejo : man_aspersao;
        stop_c    = (tmr_cnt == '0) || (manual_q ? !man_sel_c : umido);
    end

    // Scheduler next-state and registered request outputs.
    always_comb begin
        sched_d     = sched_q;
        got_d       = got_q;
        asp_d       = asp_q;
        countli_d   = countli_q;
        manual_d    = manual_q;
        li_loaded_d = li_loaded_q;
        tmr_clear   = 1'b0;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;
        tmr_val     = '0;
        if (state == TK_ERRO) begin
            sched_d     = S_IDLE;
            got_d       = 1'b0;
            asp_d       = 1'b0;
            countli_d   = 1'b0;
            li_loaded_d = 1'b0;
            tmr_clear   = 1'b1;
        end else begin
            unique case (sched_q)
                S_IDLE: begin
                    if (state == TK_CHEIO && sel_got_c) begin
                        sched_d  = S_GOTEJO;
                        got_d    = 1'b1;
                        manual_d = modo_manual;
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(T_GOTEJO);
                    end else if (state == TK_CHEIO && sel_asp_c) begin
                        sched_d  = S_ASPERSAO;
                        asp_d    = 1'b1;
                        manual_d = modo_manual;
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(T_ASPERSAO);
                    end
                end
                S_GOTEJO, S_ASPERSAO: begin
                    // Leaving freezes the counter so the remaining time stays visible.
                    if (stop_c) begin
                        sched_d     = S_LIMPEZA;
                        got_d       = 1'b0;
                        asp_d       = 1'b0;
                        li_loaded_d = 1'b0;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                S_LIMPEZA: begin
                    if (!li_loaded_q) begin
                        if (state == TK_LIMPEZA) begin
                            tmr_load    = 1'b1;
                            tmr_val     = CNT_W'(T_LIMPEZA);
                            li_loaded_d = 1'b1;
                        end
                    end else if (state != TK_LIMPEZA) begin
                        sched_d     = S_IDLE;
                        countli_d   = 1'b0;
                        li_loaded_d = 1'b0;
                        tmr_clear   = 1'b1;
                    end else begin
                        tmr_en = 1'b1;
                        // Flag done on the same edge the counter lands on zero.
                        if (tmr_cnt == '0 || (tmr_cnt == CNT_W'(1) && tick)) begin
                            countli_d = 1'b1;
                        end
                    end
                end
                default: sched_d = S_IDLE;
            endcase
        end
    end

    // Fill timer: counts ticks while filling, alarm latches at the limit.
    always_comb begin
        fill_d   = fill_q;
        alarme_d = alarme_q;
        if (state == TK_ENCHENDO) begin
            if (tick && fill_q != '1) begin
                fill_d = fill_q + CNT_W'(1);
            end
            if (fill_d >= CNT_W'(T_ENCHE_MAX)) begin
                alarme_d = 1'b1;
            end
        end else begin
            fill_d   = '0;
            alarme_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sched_q     <= S_IDLE;
            got_q       <= 1'b0;
            asp_q       <= 1'b0;
            countli_q   <= 1'b0;
            alarme_q    <= 1'b0;
            manual_q    <= 1'b0;
            li_loaded_q <= 1'b0;
            fill_q      <= '0;
        end else begin
            sched_q     <= sched_d;
            got_q       <= got_d;
            asp_q       <= asp_d;
            countli_q   <= countli_d;
            alarme_q    <= alarme_d;
            manual_q    <= manual_d;
            li_loaded_q <= li_loaded_d;
            fill_q      <= fill_d;
        end
    end

    assign gotejamento    = got_q;
    assign aspersao       = asp_q;
    assign countLi        = countli_q;
    assign alarme_enche   = alarme_q;
    assign tempo_restante = tmr_cnt;

endmodule

// File: tb/tb_irrig_scheduler.sv
// Directed bench for irrig_scheduler with default timing parameters.
module tb_irrig_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [2:0] state;
    logic       seco, umido, temp_alta;
    logic       modo_manual, man_gotejo, man_aspersao;
    logic       gotejamento, aspersao, countLi, alarme_enche;
    logic [7:0] tempo_restante;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0] st;
        logic       seco;
        logic       umido;
        logic       talta;
        logic       man;
        logic       mg;
        logic       ma;
        logic       tk;
        logic       e_got;
        logic       e_asp;
        logic       e_li;
        logic [7:0] e_tr;
        logic       e_al;
    } vec_t;

    vec_t tbl [15];

    irrig_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .tick           (tick),
        .state          (state),
        .seco           (seco),
        .umido          (umido),
        .temp_alta      (temp_alta),
        .modo_manual    (modo_manual),
        .man_gotejo     (man_gotejo),
        .man_aspersao   (man_aspersao),
        .gotejamento    (gotejamento),
        .aspersao       (aspersao),
        .countLi        (countLi),
        .tempo_restante (tempo_restante),
        .alarme_enche   (alarme_enche)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] st, input logic s, input logic u,
                                input logic ta, input logic m, input logic mg,
                                input logic ma, input logic tk, input logic eg,
                                input logic ea, input logic el, input logic [7:0] et,
                                input logic eal);
        vec_t v;
        v.st = st; v.seco = s; v.umido = u; v.talta = ta; v.man = m;
        v.mg = mg; v.ma = ma; v.tk = tk; v.e_got = eg; v.e_asp = ea;
        v.e_li = el; v.e_tr = et; v.e_al = eal;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [2:0] st, input logic s, input logic u, input logic ta,
                          input logic m, input logic mg, input logic ma, input logic tk);
        state = st; seco = s; umido = u; temp_alta = ta;
        modo_manual = m; man_gotejo = mg; man_aspersao = ma; tick = tk;
    endtask

    task automatic chk_all(input string nm);
        chk({nm, ".got"}, 32'(gotejamento), 0);
        chk({nm, ".asp"}, 32'(aspersao), 0);
        chk({nm, ".li"},  32'(countLi), 0);
        chk({nm, ".tr"},  32'(tempo_restante), 0);
        chk({nm, ".al"},  32'(alarme_enche), 0);
    endtask

    initial begin
        // st, seco, umido, talta, man, mg, ma, tk | got, asp, li, tr, al
        tbl[0]  = mk(3'b001, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0);
        tbl[1]  = mk(3'b001, 0, 0, 0, 1, 1, 1, 1,  1, 0, 0, 60, 0);
        tbl[2]  = mk(3'b010, 0, 0, 0, 1, 1, 1, 1,  1, 0, 0, 59, 0);
        tbl[3]  = mk(3'b010, 1, 0, 1, 1, 1, 0, 1,  1, 0, 0, 58, 0);
        tbl[4]  = mk(3'b010, 0, 0, 0, 1, 0, 1, 1,  0, 0, 0, 58, 0);
        tbl[5]  = mk(3'b100, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 10, 0);
        tbl[6]  = mk(3'b100, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0,  9, 0);
        tbl[7]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0);
        tbl[8]  = mk(3'b001, 0, 0, 0, 1, 0, 1, 0,  0, 1, 0, 30, 0);
        tbl[9]  = mk(3'b011, 0, 0, 0, 1, 0, 1, 1,  0, 1, 0, 29, 0);
        tbl[10] = mk(3'b101, 0, 0, 0, 1, 0, 1, 1,  0, 0, 0,  0, 0);
        tbl[11] = mk(3'b001, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0,  0, 0);
        tbl[12] = mk(3'b001, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 60, 0);
        tbl[13] = mk(3'b101, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0,  0, 0);
        tbl[14] = mk(3'b001, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0);

        reset = 1'b1;
        set_in(3'b001, 1, 0, 0, 0, 0, 0, 1);
        cyc();
        cyc();
        chk_all("reset");
        reset = 1'b0;
        set_in(3'b001, 0, 0, 0, 0, 0, 0, 0);

        // Table: manual priority, manual stop, cleaning load, error aborts.
        for (int r = 0; r < 15; r++) begin
            set_in(tbl[r].st, tbl[r].seco, tbl[r].umido, tbl[r].talta,
                   tbl[r].man, tbl[r].mg, tbl[r].ma, tbl[r].tk);
            cyc();
            chk($sformatf("row%0d.got", r), 32'(gotejamento),    32'(tbl[r].e_got));
            chk($sformatf("row%0d.asp", r), 32'(aspersao),       32'(tbl[r].e_asp));
            chk($sformatf("row%0d.li",  r), 32'(countLi),        32'(tbl[r].e_li));
            chk($sformatf("row%0d.tr",  r), 32'(tempo_restante), 32'(tbl[r].e_tr));
            chk($sformatf("row%0d.al",  r), 32'(alarme_enche),   32'(tbl[r].e_al));
        end

        // Auto drip, tick on the load edge ignored, sensors changing mid-phase.
        set_in(3'b001, 1, 0, 0, 0, 0, 0, 1);
        cyc();
        chk("drip.start.got", 32'(gotejamento), 1);
        chk("drip.start.tr",  32'(tempo_restante), 60);
        state = 3'b010;
        for (int i = 1; i <= 60; i++) begin
            if (i == 30) begin
                seco = 1'b0;
                temp_alta = 1'b1;
            end
            tick = 1'b1;
            cyc();
            chk($sformatf("drip.t%0d.tr", i),  32'(tempo_restante), 32'(60 - i));
            chk($sformatf("drip.t%0d.got", i), 32'(gotejamento), 1);
            chk($sformatf("drip.t%0d.asp", i), 32'(aspersao), 0);
        end
        tick = 1'b0;
        cyc();
        chk("drip.end.got", 32'(gotejamento), 0);
        chk("drip.end.tr",  32'(tempo_restante), 0);

        // Cleaning interval and done handshake.
        state = 3'b100;
        cyc();
        chk("clean.load.tr", 32'(tempo_restante), 10);
        chk("clean.load.li", 32'(countLi), 0);
        for (int i = 1; i <= 10; i++) begin
            tick = 1'b1;
            cyc();
            chk($sformatf("clean.t%0d.tr", i), 32'(tempo_restante), 32'(10 - i));
            chk($sformatf("clean.t%0d.li", i), 32'(countLi), 32'(i == 10));
        end
        tick = 1'b0;
        cyc();
        chk("clean.hold.li", 32'(countLi), 1);
        state = 3'b000;
        cyc();
        chk("clean.exit.li", 32'(countLi), 0);

        // Fill timeout at exactly T_ENCHE_MAX ticks.
        for (int i = 1; i <= 121; i++) begin
            tick = 1'b1;
            cyc();
            chk($sformatf("fill.t%0d.al", i), 32'(alarme_enche), 32'(i >= 120));
        end
        tick = 1'b0;
        set_in(3'b001, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        chk("fill.clear.al", 32'(alarme_enche), 0);

        // Early stop on wet soil during sprinkling.
        set_in(3'b001, 1, 0, 1, 0, 0, 0, 0);
        cyc();
        chk("wet.start.asp", 32'(aspersao), 1);
        chk("wet.start.got", 32'(gotejamento), 0);
        chk("wet.start.tr",  32'(tempo_restante), 30);
        state = 3'b011;
        for (int i = 1; i <= 5; i++) begin
            tick = 1'b1;
            cyc();
        end
        chk("wet.t5.tr", 32'(tempo_restante), 25);
        umido = 1'b1;
        cyc();
        chk("wet.stop.asp", 32'(aspersao), 0);
        chk("wet.stop.tr",  32'(tempo_restante), 25);
        tick = 1'b0;
        state = 3'b100;
        cyc();
        chk("wet.clean.tr", 32'(tempo_restante), 10);
        set_in(3'b000, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        chk("wet.exit.tr", 32'(tempo_restante), 0);

        // Asynchronous reset in the middle of a drip phase.
        set_in(3'b001, 1, 0, 0, 0, 0, 0, 0);
        cyc();
        chk("rst.start.got", 32'(gotejamento), 1);
        state = 3'b010;
        tick = 1'b1;
        cyc();
        cyc();
        chk("rst.mid.tr", 32'(tempo_restante), 58);
        #2;
        reset = 1'b1;
        #1;
        chk_all("rst.async");
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("rst.after%0d.got", i), 32'(gotejamento), 0);
            chk($sformatf("rst.after%0d.tr", i),  32'(tempo_restante), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irrig_scheduler.md
IRRIG_SCHEDULER -- requirements
Module: irrig_scheduler

Interface
REQ-001 SHALL have parameter T_GOTEJO, default 60, drip duration in ticks (1..255).
REQ-002 SHALL have parameter T_ASPERSAO, default 30, sprinkler duration in ticks (1..255).
REQ-003 SHALL have parameter T_LIMPEZA, default 10, cleaning duration in ticks (1..255).
REQ-004 SHALL have parameter T_ENCHE_MAX, default 120, fill timeout in ticks (1..255).
REQ-005 SHALL have port clk  input  1  single system clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port tick  input  1  one-clk time-base enable pulse.
REQ-008 SHALL have port state  input  3  current tank FSM state (000 enchendo, 001 cheio, 010 gotejando, 011 aspersao, 100 limpeza, 101 erro).
REQ-009 SHALL have ports seco, umido, temp_alta  input  1 each  soil-dry, soil-wet and high-temperature sensors.
REQ-010 SHALL have ports modo_manual, man_gotejo, man_aspersao  input  1 each  manual mode select and manual requests.
REQ-011 SHALL have ports gotejamento, aspersao, countLi  output  1 each  requests to the tank FSM.
REQ-012 SHALL have port tempo_restante  output  8  remaining ticks of the active phase, 0 otherwise.
REQ-013 SHALL have port alarme_enche  output  1  fill-timeout alarm.

Function
REQ-014 SHALL implement states S_IDLE, S_GOTEJO, S_ASPERSAO, S_LIMPEZA; all outputs registered.
REQ-015 S_IDLE: when state==001, SHALL select the next phase in the same clk; auto mode (modo_manual=0): seco&temp_alta -> S_ASPERSAO, seco&!temp_alta -> S_GOTEJO, else stay.
REQ-016 Manual mode: man_gotejo -> S_GOTEJO; man_aspersao alone -> S_ASPERSAO; both asserted -> S_GOTEJO (drip priority).
REQ-017 On entering S_GOTEJO/S_ASPERSAO the counter SHALL load T_GOTEJO/T_ASPERSAO, and gotejamento/aspersao SHALL assert on the next clk.
REQ-018 Counter SHALL decrement by 1 on each tick while active, never wrapping below 0; tempo_restante mirrors it.
REQ-019 Irrigation phase SHALL end when counter reaches 0, or in auto mode when umido=1, or in manual mode when the selecting man_* input drops; request output deasserts, next state S_LIMPEZA.
REQ-020 S_LIMPEZA: counter SHALL load T_LIMPEZA on first clk with state==100 and decrement on tick; at 0 countLi SHALL assert and hold until state!=100, then S_IDLE with countLi=0.
REQ-021 state==101 in any state SHALL force S_IDLE next clk, clearing gotejamento, aspersao, countLi and counter.
REQ-022 Fill timer: while state==000 SHALL count ticks (saturating at 255); when count reaches T_ENCHE_MAX alarme_enche SHALL set and hold until state!=000, which also clears the fill timer.
REQ-023 tick coincident with phase load SHALL be ignored (load wins).
REQ-024 Sensor changes during a phase SHALL NOT change the selected phase.

Reset
REQ-025 reset SHALL asynchronously force S_IDLE, counters to 0, and gotejamento, aspersao, countLi, alarme_enche, tempo_restante to 0.
REQ-026 Reset asserted mid-phase SHALL abort the phase with no further request pulses after deassertion until a new selection.

Structure
REQ-027 Tank-FSM state encodings and scheduler state typedef SHALL live in shared package irrig_pkg, used by both tank FSM and scheduler.
REQ-028 The loadable 8-bit saturating down-counter with tick enable SHALL be sub-module tick_timer, instantiated once for phases; the fill timer stays inline.

Verification
REQ-029 Auto drip: state=001, seco=1, temp_alta=0 -> gotejamento=1 for 60 ticks, then 0, tempo_restante counts 60..0.
REQ-030 Early wet stop: auto sprinkler, umido=1 after 5 ticks -> aspersao drops next clk, tempo_restante frozen then reloads 10 in limpeza.
REQ-031 Manual both: modo_manual=1, man_gotejo=man_aspersao=1 -> gotejamento only.
REQ-032 Cleaning: state=100 for 10 ticks -> countLi=1 on 10th tick, cleared the clk after state=000.
REQ-033 Error abort: state=101 mid-drip -> all request outputs 0 next clk, scheduler in S_IDLE.
REQ-034 Fill timeout: state=000 for 120 ticks -> alarme_enche=1; state=001 -> alarme_enche=0; reset mid-phase -> all outputs 0 immediately.
